// File: rtl/err_wd_pkg.sv
// Shared types and constants for the error/watchdog monitor.
package err_wd_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } wd_state_e;

  localparam logic [1:0] KIND_NONE    = 2'd0;
  localparam logic [1:0] KIND_SRC     = 2'd1;
  localparam logic [1:0] KIND_TIMEOUT = 2'd2;

  // Counter/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit priority encoder: idx_o is the smallest index with req_i set.
module prio_enc_lsb #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    // Scan downward so the lowest set bit is the last (winning) assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = W'(i);
    end
  end

endmodule

// File: rtl/err_watchdog.sv
// Merges sticky source errors, a no-progress watchdog and halt detection into
// one registered err flag with a latched cause; HALT and FAULT hold until reset.
module err_watchdog
  import err_wd_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int TIMEOUT = 64,
  parameter int HOLDOFF = 2,
  parameter int CNT_W   = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SRC-1:0]              err_src,
  input  logic                            progress,
  input  logic                            halt,
  output logic                            err,
  output logic [1:0]                      err_kind,
  output logic [clog2_min1(NUM_SRC)-1:0]  err_idx,
  output logic                            halted,
  output logic [CNT_W-1:0]                cycle_cnt,
  output logic [1:0]                      dbg_state_o
);

  localparam int IDX_W  = clog2_min1(NUM_SRC);
  localparam int HOLD_W = clog2_min1(HOLDOFF);
  localparam int IDLE_W = clog2_min1(TIMEOUT);

  wd_state_e          state_q;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic               err_q, halted_q;
  logic [1:0]         kind_q;
  logic [IDX_W-1:0]   idx_q;

  logic               src_any;
  logic [IDX_W-1:0]   src_idx;
  logic               timeout_hit;

  prio_enc_lsb #(
    .N(NUM_SRC),
    .W(IDX_W)
  ) u_prio (
    .req_i(err_src),
    .idx_o(src_idx),
    .any_o(src_any)
  );

  always_comb begin
    hold_d      = hold_q + 1'b1;
    idle_d      = progress ? '0 : idle_q + 1'b1;
    cyc_d       = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;
    // A progress pulse on the would-be timeout cycle rescues the run.
    timeout_hit = !progress && (idle_q == IDLE_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HOLD;
      hold_q   <= '0;
      idle_q   <= '0;
      cyc_q    <= '0;
      err_q    <= 1'b0;
      kind_q   <= KIND_NONE;
      idx_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          hold_q <= hold_d;
          if (hold_q == HOLD_W'(HOLDOFF - 1)) state_q <= RUN;
        end
        RUN: begin
          cyc_q  <= cyc_d;
          idle_q <= idle_d;
          if (src_any) begin
            state_q <= FAULT;
            err_q   <= 1'b1;
            kind_q  <= KIND_SRC;
            idx_q   <= src_idx;
          end else if (timeout_hit) begin
            state_q <= FAULT;
            err_q   <= 1'b1;
            kind_q  <= KIND_TIMEOUT;
            idx_q   <= '0;
          end else if (halt) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end
        end
        default: ; // HALT and FAULT are terminal until reset
      endcase
    end
  end

  assign err         = err_q;
  assign err_kind    = kind_q;
  assign err_idx     = idx_q;
  assign halted      = halted_q;
  assign cycle_cnt   = cyc_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/err_watchdog.md
Name: err_watchdog

Overview:
- Error/watchdog monitor sitting directly upstream of the testbench clock/reset generator; drives its err input.
- Merges sticky per-source error flags from the processor under test with a no-progress watchdog and halt detection into one registered err output plus a latched cause code.
- Runs on the generator's clock and reset; all outputs are terminal until the next reset.

Parameters:
- NUM_SRC, 4, number of error source inputs (1..16)
- TIMEOUT, 64, cycles without a progress pulse before a timeout fault (>=2)
- HOLDOFF, 2, cycles after reset release during which err_src is ignored (>=1)
- CNT_W, 16, width of the cycle counter

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- err_src  in  NUM_SRC  per-source error flags, level, sampled each cycle
- progress  in  1  one-cycle pulse per retired instruction
- halt  in  1  processor halt indication, level
- err  out  1  registered fault flag, drives the generator's err input
- err_kind  out  2  0 = none, 1 = source error, 2 = timeout, 3 = reserved
- err_idx  out  $clog2(NUM_SRC) (min 1)  index of the faulting source, valid when err_kind = 1
- halted  out  1  registered, high once clean halt is seen
- cycle_cnt  out  CNT_W  cycles spent in RUN, saturating

Behaviour:
- Reset (rst_n low, async): state = HOLD; err = 0, err_kind = 0, err_idx = 0, halted = 0, cycle_cnt = 0; holdoff and idle counters = 0.
- States: HOLD, RUN, HALT, FAULT. HALT and FAULT are terminal until reset.
- HOLD: holdoff counter increments each cycle; err_src, progress and halt are ignored. Moves to RUN on the edge where the counter equals HOLDOFF-1, so RUN begins exactly HOLDOFF cycles after reset release.
- RUN, evaluated each cycle, priority highest first:
  1. Any err_src bit set -> FAULT, err_kind = 1, err_idx = lowest set index.
  2. No progress this cycle and idle counter == TIMEOUT-1 -> FAULT, err_kind = 2, err_idx = 0.
  3. halt high -> HALT, halted = 1.
  4. Otherwise stay in RUN.
- Idle counter (RUN only): cleared on progress, otherwise incremented. Progress in the same cycle as the would-be timeout clears the counter and no fault is raised.
- Latency: err, err_kind, err_idx and halted are all registered and update on the edge that samples the cause; they are visible 1 cycle after the cause is presented.
- Simultaneous events: err_src together with halt -> FAULT (err_kind = 1). Timeout together with halt -> FAULT (err_kind = 2).
- cycle_cnt: increments once per cycle spent in RUN, including the transition cycle out of RUN. Saturates at 2^CNT_W-1 and does not wrap. Frozen in HOLD, HALT and FAULT.
- In HALT and FAULT, every input is ignored and outputs hold their values.
- Reset mid-operation (any state): all outputs clear immediately (async), and HOLD restarts.
- err_kind = 3 is never produced.

Decomposition:
- Shared package err_wd_pkg holds:
  - state enum {HOLD, RUN, HALT, FAULT};
  - err_kind constants KIND_NONE / KIND_SRC / KIND_TIMEOUT.
- One natural sub-module, prio_enc_lsb: parameterised lowest-set-bit priority encoder producing err_idx and an any flag.
- Counters and the FSM stay in the top level.

Test Plan:
- Reset release with err_src = 4'b1111 held through HOLDOFF = 2 -> err stays 0 for the 2 HOLD cycles; err = 1, err_kind = 1, err_idx = 0 one cycle after RUN is entered.
- In RUN, err_src = 4'b1010 for one cycle -> err = 1, err_kind = 1, err_idx = 1; outputs hold after err_src returns to 0.
- TIMEOUT = 64 and no progress after RUN entry -> err rises 64 cycles after RUN entry with err_kind = 2. Progress pulse on the 64th cycle -> no fault.
- halt = 1 at RUN cycle 10 with progress every cycle -> halted = 1 next cycle, err = 0, cycle_cnt frozen at 10; later err_src = 4'b0001 -> no change.
- halt together with err_src = 4'b0100 in the same cycle -> err = 1, err_kind = 1, err_idx = 2, halted = 0.
- CNT_W = 4 with progress every cycle -> cycle_cnt saturates at 15 after 15 RUN cycles; rst_n pulsed low mid-RUN -> all outputs 0 immediately, HOLD restarts.
